// File: rtl/multiplicador_datapath.sv
// -----------------------------------------------------------------------------
// multiplicador_datapath
//
// Shift-add datapath of the MMP multiplier. It sits directly downstream of the
// Controlador. It executes the Load_regs / Add_regs / Shift_regs / Decr_P
// commands and returns the status bits Q0 and Zero.
//
// Registers:
//   B : multiplicand.
//   A : accumulator, with carry C.
//   Q : multiplier, which becomes the low half of the product.
//   P : iteration counter.
//
// Parameters:
//   WIDTH : operand width in bits. The product is 2*WIDTH bits.
//   PW    : counter width, $clog2(WIDTH+1) (derived localparam).
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-low reset
//   multiplicand in   WIDTH    operand B, sampled on Load_regs
//   multiplier   in   WIDTH    operand Q, sampled on Load_regs
//   Load_regs    in   1        load operands, clear A/C, P <= WIDTH (highest priority)
//   Add_regs     in   1        {C,A} <= A + B
//   Shift_regs   in   1        {C,A,Q} >> 1, C <= 0 (sum first if Add_regs too)
//   Decr_P       in   1        P <= P - 1, saturating at 0
//   ready        in   1        multiplication finished
//   Q0           out  1        Q[0], combinational from the register
//   Zero         out  1        P == 0, combinational from the register
//   product      out  2*WIDTH  multiplication result
//
// Build option:
//   MMP_DP_RESULT_REG_EN
//     Defined:   product comes from a result register R. R captures {A,Q} on
//                the rising edge of ready and holds it until the next rise.
//     Undefined: product = {A,Q} combinationally.
// -----------------------------------------------------------------------------
module multiplicador_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               Load_regs,
  input  logic               Add_regs,
  input  logic               Shift_regs,
  input  logic               Decr_P,
  input  logic               ready,
  output logic               Q0,
  output logic               Zero,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             c_reg, c_next;
  logic [PW-1:0]    p_reg, p_next;

  // WIDTH+1-bit sum; the top bit is the carry into C.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a_reg} + {1'b0, b_reg};

  // Upper WIDTH+1 bits that get shifted down into A and Q.
  // On a combined add+shift the fresh sum is shifted; otherwise {C,A} is shifted.
  logic [WIDTH:0] shift_src;
  assign shift_src = Add_regs ? sum : {c_reg, a_reg};

  // Shifted Q: the bit leaving the upper half enters Q's MSB.
  logic [WIDTH-1:0] q_shifted;
  assign q_shifted[WIDTH-1] = shift_src[0];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_q_shift
      assign q_shifted[gi] = q_reg[gi+1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    q_next = q_reg;
    c_next = c_reg;
    p_next = p_reg;

    if (Load_regs) begin
      // Load wins over all other commands and aborts any product in flight.
      b_next = multiplicand;
      q_next = multiplier;
      a_next = '0;
      c_next = 1'b0;
      p_next = PW'(WIDTH);
    end else begin
      if (Shift_regs) begin
        a_next = shift_src[WIDTH:1];
        q_next = q_shifted;
        c_next = 1'b0;
      end else if (Add_regs) begin
        {c_next, a_next} = sum;
      end

      // The counter saturates at zero so a stray Decr_P cannot wrap it.
      if (Decr_P && (p_reg != '0)) begin
        p_next = p_reg - PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      c_reg <= 1'b0;
      p_reg <= '0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
      q_reg <= q_next;
      c_reg <= c_next;
      p_reg <= p_next;
    end
  end

  // Status back to the controller with no register delay.
  assign Q0   = q_reg[0];
  assign Zero = (p_reg == '0);

  // ---------------------------------------------------------------------------
  // Result presentation
  // ---------------------------------------------------------------------------
`ifdef MMP_DP_RESULT_REG_EN
  logic               ready_d_reg;
  logic [2*WIDTH-1:0] r_reg;
  logic               ready_rise;

  assign ready_rise = ready && !ready_d_reg;

  // R captures only on the rising edge of ready. This lets the result survive
  // a following Load_regs while the next product is being computed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_d_reg <= 1'b0;
      r_reg       <= '0;
    end else begin
      ready_d_reg <= ready;
      if (ready_rise) begin
        r_reg <= {a_reg, q_reg};
      end
    end
  end

  assign product = r_reg;
`else
  // ready only qualifies validity for the consumer in this build.
  logic unused_ready;
  assign unused_ready = ready;

  assign product = {a_reg, q_reg};
`endif

endmodule

// File: tb/tb_multiplicador_datapath.sv
module tb_multiplicador_datapath;

  logic        clk;
  logic        rst;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        Load_regs;
  logic        Add_regs;
  logic        Shift_regs;
  logic        Decr_P;
  logic        ready;
  logic        Q0;
  logic        Zero;
  logic [15:0] product;

  int tests_run    = 0;
  int tests_failed = 0;

  multiplicador_datapath #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .Load_regs    (Load_regs),
    .Add_regs     (Add_regs),
    .Shift_regs   (Shift_regs),
    .Decr_P       (Decr_P),
    .ready        (ready),
    .Q0           (Q0),
    .Zero         (Zero),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // One clock edge; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Load_regs  = 1'b0;
    Add_regs   = 1'b0;
    Shift_regs = 1'b0;
    Decr_P     = 1'b0;
  endtask

  task automatic load(input logic [7:0] b, input logic [7:0] q);
    multiplicand = b;
    multiplier   = q;
    Load_regs    = 1'b1;
    tick();
    idle();
  endtask

  // Controller-style run after a load.
  // Each iteration: {Add if Q0, Decr_P}, then Shift.
  task automatic iterate(input logic [7:0] q);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("Q0 iter %0d", i), {15'd0, Q0}, {15'd0, q[i]});
      Add_regs = Q0;
      Decr_P   = 1'b1;
      tick();
      idle();
      check($sformatf("Zero iter %0d", i), {15'd0, Zero}, (i == 7) ? 16'd1 : 16'd0);
      Shift_regs = 1'b1;
      tick();
      idle();
    end
  endtask

  task automatic finish_ready();
    ready = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{8'd5,   8'd3,   16'd15};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd7,   8'd7,   16'd49};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd13,  8'd11,  16'd143};
    vecs[7] = '{8'd255, 8'd1,   16'd255};
    vecs[8] = '{8'd200, 8'd100, 16'h4E20};
    vecs[9] = '{8'd1,   8'd255, 16'd255};

    rst = 1'b0;
    ready = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    idle();

    // Reset state, observed before any clock edge.
    #1;
    check("reset Q0", {15'd0, Q0}, 16'd0);
    check("reset Zero", {15'd0, Zero}, 16'd1);
    check("reset product", product, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // Table-driven products.
    for (int v = 0; v < 10; v++) begin
      ready = 1'b0;
      load(vecs[v].b, vecs[v].q);
      check("Zero after load", {15'd0, Zero}, 16'd0);
      iterate(vecs[v].q);
      finish_ready();
      check($sformatf("product %0dx%0d", vecs[v].b, vecs[v].q), product, vecs[v].exp);
      $display("[TB] vec %0d: %0d x %0d -> 0x%h (expected 0x%h)",
               v, vecs[v].b, vecs[v].q, product, vecs[v].exp);
    end

    // Async reset in the middle of a run, checked between clock edges.
    ready = 1'b0;
    load(8'd5, 8'd3);
    Add_regs = 1'b1;
    Decr_P = 1'b1;
    tick();
    idle();
    #2;
    rst = 1'b0;
    #1;
    check("async rst Q0", {15'd0, Q0}, 16'd0);
    check("async rst Zero", {15'd0, Zero}, 16'd1);
    check("async rst product", product, 16'd0);
    #1;
    rst = 1'b1;
    tick();
    check("post rst product", product, 16'd0);
    $display("[TB] mid-run async reset -> product 0x%h Zero %0b", product, Zero);

    // Load priority: all commands asserted with Load.
    multiplicand = 8'd9;
    multiplier = 8'd6;
    Load_regs = 1'b1;
    Add_regs = 1'b1;
    Shift_regs = 1'b1;
    Decr_P = 1'b1;
    tick();
    idle();
    check("load priority Zero", {15'd0, Zero}, 16'd0);
    check("load priority Q0", {15'd0, Q0}, 16'd0);
`ifndef MMP_DP_RESULT_REG_EN
    check("load priority product", product, 16'h0006);
`endif
    $display("[TB] load with all commands -> product 0x%h", product);

    // Combined add+shift with A=0x80, B=0x80, Q=0x01.
    load(8'h80, 8'h01);
    Add_regs = 1'b1;
    tick();
    idle();
`ifndef MMP_DP_RESULT_REG_EN
    check("add A=80", product, 16'h8001);
`endif
    Add_regs = 1'b1;
    Shift_regs = 1'b1;
    tick();
    idle();
`ifndef MMP_DP_RESULT_REG_EN
    check("add+shift", product, 16'h8000);
`endif
    check("add+shift Q0", {15'd0, Q0}, 16'd0);
    // A plain shift now reveals C: it must be 0, so A becomes 0x40.
    Shift_regs = 1'b1;
    tick();
    idle();
`ifndef MMP_DP_RESULT_REG_EN
    check("shift after add+shift C=0", product, 16'h4000);
`endif
    $display("[TB] add+shift corner -> product 0x%h", product);

    // Decrement to 0, then saturate.
    for (int i = 0; i < 8; i++) begin
      Decr_P = 1'b1;
      tick();
    end
    idle();
    check("Zero after 8 Decr", {15'd0, Zero}, 16'd1);
    Decr_P = 1'b1;
    tick();
    tick();
    idle();
    check("Zero saturate", {15'd0, Zero}, 16'd1);
    // If P had wrapped it would need another load to recover; reload shows P=WIDTH again.
    load(8'd1, 8'd1);
    check("Zero after reload", {15'd0, Zero}, 16'd0);
    $display("[TB] Decr_P saturation -> Zero %0b", Zero);

    // Result hold behaviour across a new Load.
    ready = 1'b0;
    load(8'd5, 8'd3);
    iterate(8'd3);
    finish_ready();
    check("hold first product", product, 16'd15);
    ready = 1'b0;
    load(8'd7, 8'd7);
`ifdef MMP_DP_RESULT_REG_EN
    check("hold after load", product, 16'd15);
`else
    check("product after load", product, 16'd7);
`endif
    iterate(8'd7);
`ifdef MMP_DP_RESULT_REG_EN
    check("hold before ready", product, 16'd15);
`endif
    finish_ready();
    check("second product", product, 16'd49);
    $display("[TB] hold sequence 5x3 then 7x7 -> 0x%h", product);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
